bcd_rtc_core: RTL and testbench
===============================

# bcd_rtc_core

Parametrised successor to the lab digital clock: a six-digit BCD time-of-day counter (HH:MM:SS) with a configurable tick source, a validated synchronous time-load port, 12/24-hour display mapping and rollover pulses. It sits between the board clock and the seven-segment display driver. It is the single owner of time state for the display and any alarm or timer logic downstream.

## Interface
- `TICK_DIV`, 100_000_000 — clk cycles per second in internal-tick mode; legal range ≥2.
- `EXT_TICK`, 0 — 0: internal divider generates the seconds tick; 1: rising edges on `trigger` generate it and the divider is held at 0.
- `DIV_W`, `$clog2(TICK_DIV)` — divider width (localparam).
- `clk` in 1 — system clock.
- `sw` in 1 — reset; synchronous, active-high.
- `trigger` in 1 — external seconds tick; asynchronous to `clk`; used only when `EXT_TICK=1`.
- `mode12` in 1 — 1 selects the 12-hour display mapping; 0 selects 24-hour.
- `set_en` in 1 — single-cycle load strobe.
- `set_h2`, `set_h1`, `set_m2`, `set_m1`, `set_s2`, `set_s1` in 4 each — load value, always in 24-hour BCD.
- `set_err` out 1 — registered one-cycle pulse when a load is rejected.
- `h2`, `h1`, `m2`, `m1`, `s2`, `s1` out 4 each — displayed BCD digits (tens then units).
- `pm` out 1 — 1 for hours 12–23 when `mode12=1`; 0 when `mode12=0`.
- `sec_pulse`, `min_pulse`, `day_pulse` out 1 — registered one-cycle rollover pulses.
- `alarm_set`, `alarm_on`, `alarm_ack` in 1 — alarm control (see Configuration).
- `alarm_hit` out 1 — alarm flag.

## Operation
- Internal state is 24-hour BCD (`hh` 00–23, `mm` 00–59, `ss` 00–59) plus the divider.
- Reset: time = 00:00:00, divider = 0, all pulses = 0, `set_err` = 0, `alarm_hit` = 0, alarm register = 00:00, sync flops = 0.
- Internal tick: the divider counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and the time increments.
- External tick: `trigger` passes through a 2-flop synchroniser and then a previous-value flop. A tick is `q2 & ~q3`.
- Increment:
  - `s1` 9→0 carries into `s2`; `s2`=5 with `s1`=9 wraps both to 0 and carries into minutes. Minutes use the same rule.
  - Hours advance 23→00. 09→10 and 19→20 carry units into tens.
- Pulses:
  - `sec_pulse` on every increment.
  - `min_pulse` when seconds wrap.
  - `day_pulse` when 23:59:59→00:00:00. All three assert together on that transition.
- Load:
  - Accepted only if every digit is BCD (≤9), `set_s2`≤5, `set_m2`≤5, and hours ≤23.
  - Accepted load: time takes the value and the divider clears to 0.
  - Rejected load: time is unchanged and `set_err` pulses.
- Priority: `sw` > accepted load > tick. A tick coinciding with an accepted load is discarded, with no pulses. A tick coinciding with a rejected load is applied normally.
- 12-hour mapping (combinational from `hh`):
  - 00→12, pm=0.
  - 01–11 unchanged, pm=0.
  - 12→12, pm=1.
  - 13–23→01–11, pm=1.
- Minute and second outputs are the state registers directly.

## Timing
- Internal mode: the time changes on the clk edge where the divider equals TICK_DIV-1. Subsequent changes occur every TICK_DIV cycles.
- Pulses are high for the one cycle following the time change.
- External mode: the time changes on the 2nd clk edge after the edge that first samples `trigger` high. At most one increment per `trigger` rising edge.
- An accepted load is visible on the outputs the cycle after `set_en`. `set_err` has the same latency.
- `mode12` affects the outputs combinationally in the same cycle. State is unaffected.
- Reset mid-count clears everything on the next edge. A pending synchronised edge is lost.

## Configuration
- Macro `RTC_ALARM_EN`.
- Defined:
  - `alarm_set` loads the alarm register from `set_h2..set_m1`, using the same hour and minute validity rules; invalid values pulse `set_err`.
  - When a tick makes the time equal alarm HH:MM:00 with `alarm_on=1`, `alarm_hit` sets on that edge.
  - `alarm_hit` holds until `alarm_ack`, `sw`, or `alarm_on=0`. If ack and match occur in the same cycle, the match wins.
  - Loading the time to exactly the alarm value does not fire.
- Undefined: alarm logic is not built. `alarm_hit` is tied to 0, and the alarm inputs are ignored. Ports are identical in both builds.

## Test plan
- `TICK_DIV`=4, reset, 240 cycles → 00:01:00; `min_pulse` pulses once, `sec_pulse` pulses 60 times spaced 4 cycles apart.
- Load 23:59:58, then 2 ticks → 00:00:00; `sec_pulse`, `min_pulse` and `day_pulse` all pulse on the same cycle.
- Load 12:60:00 → `set_err`=1 for one cycle, time unchanged. Load 24:00:00 → rejected. Load 07:05:09 → accepted.
- `mode12`=1 with `hh`=00, 12, 13, 23 → outputs 12/pm0, 12/pm1, 01/pm1, 11/pm1.
- `EXT_TICK`=1, 3 `trigger` pulses each 5 cycles wide → `ss`=03, and the first change occurs 2 edges after the sampling edge. Assert `set_en` on the tick cycle → the load wins and no `sec_pulse` occurs.
- `RTC_ALARM_EN`: set alarm 00:01, `alarm_on`=1, run 60 ticks → `alarm_hit`=1 and held; `alarm_ack` clears it; with `alarm_on`=0 it never sets.

Source files
------------

// File: rtl/bcd_rtc_core.sv
// BCD HH:MM:SS time-of-day counter with validated load, 12/24h display mapping, rollover pulses; alarm built under RTC_ALARM_EN.
// Latency: load/set_err/pulses 1 cycle, external tick 2 cycles after sampling; no backpressure, free-running.
module bcd_rtc_core #(
    parameter int TICK_DIV = 100_000_000,
    parameter bit EXT_TICK = 1'b0
) (
    input  logic       clk,
    input  logic       sw,
    input  logic       trigger,
    input  logic       mode12,
    input  logic       set_en,
    input  logic [3:0] set_h2,
    input  logic [3:0] set_h1,
    input  logic [3:0] set_m2,
    input  logic [3:0] set_m1,
    input  logic [3:0] set_s2,
    input  logic [3:0] set_s1,
    output logic       set_err,
    output logic [3:0] h2,
    output logic [3:0] h1,
    output logic [3:0] m2,
    output logic [3:0] m1,
    output logic [3:0] s2,
    output logic [3:0] s1,
    output logic       pm,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       day_pulse,
    input  logic       alarm_set,
    input  logic       alarm_on,
    input  logic       alarm_ack,
    output logic       alarm_hit
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    typedef struct packed {
        logic [3:0] h2;
        logic [3:0] h1;
        logic [3:0] m2;
        logic [3:0] m1;
        logic [3:0] s2;
        logic [3:0] s1;
    } rtc_time_t;

    function automatic logic hour_ok(input logic [3:0] t, input logic [3:0] u);
        return ((t < 4'd2) && (u <= 4'd9)) || ((t == 4'd2) && (u <= 4'd3));
    endfunction

    function automatic logic sexa_ok(input logic [3:0] t, input logic [3:0] u);
        return (t <= 4'd5) && (u <= 4'd9);
    endfunction

    function automatic rtc_time_t incr(input rtc_time_t t);
        rtc_time_t n;
        n = t;
        if (t.s1 != 4'd9) begin
            n.s1 = t.s1 + 4'd1;
        end else begin
            n.s1 = 4'd0;
            if (t.s2 != 4'd5) begin
                n.s2 = t.s2 + 4'd1;
            end else begin
                n.s2 = 4'd0;
                if (t.m1 != 4'd9) begin
                    n.m1 = t.m1 + 4'd1;
                end else begin
                    n.m1 = 4'd0;
                    if (t.m2 != 4'd5) begin
                        n.m2 = t.m2 + 4'd1;
                    end else begin
                        n.m2 = 4'd0;
                        if ((t.h2 == 4'd2) && (t.h1 == 4'd3)) begin
                            n.h2 = 4'd0;
                            n.h1 = 4'd0;
                        end else if (t.h1 == 4'd9) begin
                            n.h1 = 4'd0;
                            n.h2 = t.h2 + 4'd1;
                        end else begin
                            n.h1 = t.h1 + 4'd1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

    rtc_time_t        tm_q;
    rtc_time_t        tm_inc;
    rtc_time_t        set_tm;
    logic [DIV_W-1:0] div_q;
    logic             sync_q1, sync_q2, sync_q3;
    logic             tick_int, tick_ext, tick;
    logic             set_hm_ok, set_ok, load_ok, tick_apply;
    logic             sec_wrap, min_wrap, hr23;
    logic             alarm_rej;

    assign set_tm    = '{h2: set_h2, h1: set_h1, m2: set_m2, m1: set_m1, s2: set_s2, s1: set_s1};
    assign set_hm_ok = hour_ok(set_h2, set_h1) && sexa_ok(set_m2, set_m1);
    assign set_ok    = set_hm_ok && sexa_ok(set_s2, set_s1);
    assign load_ok   = set_en && set_ok;

    assign tick_int   = (div_q == DIV_MAX);
    assign tick_ext   = sync_q2 & ~sync_q3;
    assign tick       = EXT_TICK ? tick_ext : tick_int;
    // An accepted load swallows a coincident tick entirely, pulses included.
    assign tick_apply = tick & ~load_ok;

    assign tm_inc   = incr(tm_q);
    assign sec_wrap = (tm_q.s2 == 4'd5) && (tm_q.s1 == 4'd9);
    assign min_wrap = (tm_q.m2 == 4'd5) && (tm_q.m1 == 4'd9);
    assign hr23     = (tm_q.h2 == 4'd2) && (tm_q.h1 == 4'd3);

    always_ff @(posedge clk) begin
        if (sw) begin
            tm_q      <= '0;
            div_q     <= '0;
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            sync_q3   <= 1'b0;
            sec_pulse <= 1'b0;
            min_pulse <= 1'b0;
            day_pulse <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            sync_q1 <= trigger;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
            if (EXT_TICK || load_ok || tick_int) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
            sec_pulse <= tick_apply;
            min_pulse <= tick_apply && sec_wrap;
            day_pulse <= tick_apply && sec_wrap && min_wrap && hr23;
            set_err   <= (set_en && !set_ok) || alarm_rej;
            if (load_ok) begin
                tm_q <= set_tm;
            end else if (tick_apply) begin
                tm_q <= tm_inc;
            end
        end
    end

`ifdef RTC_ALARM_EN
    logic [3:0] al_h2, al_h1, al_m2, al_m1;
    logic       alarm_hit_q;
    logic       alarm_match;

    assign alarm_rej   = alarm_set && !set_hm_ok;
    // Only a tick can fire the alarm; a load landing on the alarm time does not.
    assign alarm_match = tick_apply && alarm_on &&
                         (tm_inc.h2 == al_h2) && (tm_inc.h1 == al_h1) &&
                         (tm_inc.m2 == al_m2) && (tm_inc.m1 == al_m1) &&
                         (tm_inc.s2 == 4'd0)  && (tm_inc.s1 == 4'd0);

    always_ff @(posedge clk) begin
        if (sw) begin
            al_h2       <= 4'd0;
            al_h1       <= 4'd0;
            al_m2       <= 4'd0;
            al_m1       <= 4'd0;
            alarm_hit_q <= 1'b0;
        end else begin
            if (alarm_set && set_hm_ok) begin
                al_h2 <= set_h2;
                al_h1 <= set_h1;
                al_m2 <= set_m2;
                al_m1 <= set_m1;
            end
            if (alarm_match) begin
                alarm_hit_q <= 1'b1;
            end else if (alarm_ack || !alarm_on) begin
                alarm_hit_q <= 1'b0;
            end
        end
    end

    assign alarm_hit = alarm_hit_q;
`else
    logic unused_alarm_in;

    assign unused_alarm_in = ^{alarm_set, alarm_on, alarm_ack};
    assign alarm_rej       = 1'b0;
    assign alarm_hit       = 1'b0;
`endif

    logic [4:0] hr_bin;
    logic [4:0] hr12;

    assign hr_bin = (5'(tm_q.h2) * 5'd10) + 5'(tm_q.h1);

    always_comb begin
        h2   = tm_q.h2;
        h1   = tm_q.h1;
        pm   = 1'b0;
        hr12 = hr_bin;
        if (mode12) begin
            pm = (hr_bin >= 5'd12);
            if (hr_bin == 5'd0) begin
                hr12 = 5'd12;
            end else if (hr_bin > 5'd12) begin
                hr12 = hr_bin - 5'd12;
            end
            if (hr12 >= 5'd10) begin
                h2 = 4'd1;
                h1 = 4'(hr12 - 5'd10);
            end else begin
                h2 = 4'd0;
                h1 = hr12[3:0];
            end
        end
    end

    assign m2 = tm_q.m2;
    assign m1 = tm_q.m1;
    assign s2 = tm_q.s2;
    assign s1 = tm_q.s1;

endmodule

// File: tb/tb_bcd_rtc_core.sv
// Directed bench for bcd_rtc_core: internal-divider instance (TICK_DIV=4) and external-trigger instance.
module tb_bcd_rtc_core;

    logic        clk = 1'b0;
    logic        sw_i = 1'b1, set_en_i = 1'b0, trig_i = 1'b0;
    logic        sw_e = 1'b1, set_en_e = 1'b0, trig_e = 1'b0;
    logic        mode12 = 1'b0;
    logic [23:0] set_tm = '0;
    logic        alarm_set = 1'b0, alarm_on = 1'b0, alarm_ack = 1'b0;

    wire  [23:0] i_tm, e_tm;
    wire         i_err, i_pm, i_sec, i_min, i_day, i_alarm;
    wire         e_err, e_pm, e_sec, e_min, e_day, e_alarm;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_rtc_core #(.TICK_DIV(4), .EXT_TICK(1'b0)) u_int (
        .clk(clk), .sw(sw_i), .trigger(trig_i), .mode12(mode12), .set_en(set_en_i),
        .set_h2(set_tm[23:20]), .set_h1(set_tm[19:16]), .set_m2(set_tm[15:12]),
        .set_m1(set_tm[11:8]), .set_s2(set_tm[7:4]), .set_s1(set_tm[3:0]),
        .set_err(i_err),
        .h2(i_tm[23:20]), .h1(i_tm[19:16]), .m2(i_tm[15:12]),
        .m1(i_tm[11:8]), .s2(i_tm[7:4]), .s1(i_tm[3:0]),
        .pm(i_pm), .sec_pulse(i_sec), .min_pulse(i_min), .day_pulse(i_day),
        .alarm_set(alarm_set), .alarm_on(alarm_on), .alarm_ack(alarm_ack), .alarm_hit(i_alarm)
    );

    bcd_rtc_core #(.TICK_DIV(4), .EXT_TICK(1'b1)) u_ext (
        .clk(clk), .sw(sw_e), .trigger(trig_e), .mode12(mode12), .set_en(set_en_e),
        .set_h2(set_tm[23:20]), .set_h1(set_tm[19:16]), .set_m2(set_tm[15:12]),
        .set_m1(set_tm[11:8]), .set_s2(set_tm[7:4]), .set_s1(set_tm[3:0]),
        .set_err(e_err),
        .h2(e_tm[23:20]), .h1(e_tm[19:16]), .m2(e_tm[15:12]),
        .m1(e_tm[11:8]), .s2(e_tm[7:4]), .s1(e_tm[3:0]),
        .pm(e_pm), .sec_pulse(e_sec), .min_pulse(e_min), .day_pulse(e_day),
        .alarm_set(1'b0), .alarm_on(1'b0), .alarm_ack(1'b0), .alarm_hit(e_alarm)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_i(input logic [23:0] v);
        set_tm   = v;
        set_en_i = 1'b1;
        @(negedge clk);
        set_en_i = 1'b0;
    endtask

    logic [23:0] m_ld  [5];
    logic [8:0]  m_exp [5];

    initial begin
        int sec_cnt, min_cnt, day_cnt, first_sec, last_sec, bad_gap, min_at, esec;

        // Reset state
        @(negedge clk);
        check("rst_time", i_tm, 24'h000000);
        check("rst_pulses", {i_sec, i_min, i_day}, 3'b000);
        check("rst_err", i_err, 1'b0);
        check("rst_alarm", i_alarm, 1'b0);
        sw_i = 1'b0;

        // 240 cycles at TICK_DIV=4 -> 60 ticks -> 00:01:00
        sec_cnt = 0; min_cnt = 0; day_cnt = 0; first_sec = 0; last_sec = 0; bad_gap = 0; min_at = 0;
        for (int c = 1; c <= 240; c++) begin
            @(negedge clk);
            if (i_sec) begin
                if (last_sec != 0 && (c - last_sec) != 4) bad_gap++;
                if (first_sec == 0) first_sec = c;
                last_sec = c;
                sec_cnt++;
            end
            if (i_min) begin
                min_cnt++;
                min_at = c;
            end
            if (i_day) day_cnt++;
        end
        check("run_time", i_tm, 24'h000100);
        check("sec_count", sec_cnt, 60);
        check("sec_first", first_sec, 4);
        check("sec_gap", bad_gap, 0);
        check("min_count", min_cnt, 1);
        check("min_at", min_at, 240);
        check("day_count", day_cnt, 0);

        // Day rollover
        load_i(24'h235958);
        check("load_235958", i_tm, 24'h235958);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 4) begin
                check("tick_235959", i_tm, 24'h235959);
                check("pulses_59", {i_sec, i_min, i_day}, 3'b100);
            end
            if (c == 8) begin
                check("tick_000000", i_tm, 24'h000000);
                check("pulses_day", {i_sec, i_min, i_day}, 3'b111);
            end
        end

        // Rejected and accepted loads
        set_tm = 24'h126000; set_en_i = 1'b1;
        @(negedge clk);
        set_en_i = 1'b0;
        check("rej_1260_err", i_err, 1'b1);
        check("rej_1260_time", i_tm, 24'h000000);
        @(negedge clk);
        check("err_one_cycle", i_err, 1'b0);
        set_tm = 24'h240000; set_en_i = 1'b1;
        @(negedge clk);
        check("rej_24_err", i_err, 1'b1);
        check("rej_24_time", i_tm, 24'h000000);
        // This accepted load lands on the divider wrap edge: tick discarded
        set_tm = 24'h070509;
        @(negedge clk);
        set_en_i = 1'b0;
        check("acc_0709_time", i_tm, 24'h070509);
        check("acc_0709_err", i_err, 1'b0);
        check("acc_tick_lost", i_sec, 1'b0);
        repeat (3) @(negedge clk);
        set_tm = 24'h07050A; set_en_i = 1'b1;
        @(negedge clk);
        set_en_i = 1'b0;
        check("rej_tick_time", i_tm, 24'h070510);
        check("rej_tick_err", i_err, 1'b1);
        check("rej_tick_sec", i_sec, 1'b1);

        // 12-hour mapping: {h2,h1,pm}
        m_ld[0] = 24'h003000; m_exp[0] = {8'h12, 1'b0};
        m_ld[1] = 24'h113000; m_exp[1] = {8'h11, 1'b0};
        m_ld[2] = 24'h123000; m_exp[2] = {8'h12, 1'b1};
        m_ld[3] = 24'h133000; m_exp[3] = {8'h01, 1'b1};
        m_ld[4] = 24'h233000; m_exp[4] = {8'h11, 1'b1};
        mode12 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            load_i(m_ld[k]);
            check($sformatf("mode12_%h", m_ld[k][23:16]), {i_tm[23:16], i_pm}, m_exp[k]);
        end
        mode12 = 1'b0;
        #1;
        check("mode24_23", {i_tm[23:16], i_pm}, {8'h23, 1'b0});

        // Reset mid-count
        @(negedge clk);
        sw_i = 1'b1;
        @(negedge clk);
        sw_i = 1'b0;
        check("rst_mid_time", i_tm, 24'h000000);
        check("rst_mid_sec", i_sec, 1'b0);

        // External trigger instance
        sw_e = 1'b0;
        @(negedge clk);
        check("ext_rst", {e_tm, e_sec, e_min, e_day, e_err, e_alarm, e_pm}, 30'h0);
        esec = 0;
        for (int k = 0; k < 3; k++) begin
            trig_e = 1'b1;
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                if (e_sec) esec++;
                if (k == 0 && c == 2) check("ext_lat_pre", e_tm, 24'h000000);
                if (k == 0 && c == 3) check("ext_lat", {e_tm, e_sec}, {24'h000001, 1'b1});
            end
            trig_e = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (e_sec) esec++;
            end
        end
        check("ext_time", e_tm, 24'h000003);
        check("ext_sec_cnt", esec, 3);

        trig_e = 1'b1;
        repeat (2) @(negedge clk);
        set_tm = 24'h070509; set_en_e = 1'b1;
        @(negedge clk);
        set_en_e = 1'b0;
        check("ext_load_wins", {e_tm, e_sec, e_err}, {24'h070509, 2'b00});
        @(negedge clk);
        check("ext_no_late", {e_tm, e_sec}, {24'h070509, 1'b0});
        trig_e = 1'b0;
        repeat (5) @(negedge clk);

`ifdef RTC_ALARM_EN
        begin
            int hit_at, hits;
            logic [23:0] hit_tm;
            sw_i = 1'b1;
            @(negedge clk);
            sw_i = 1'b0;
            set_tm = 24'h000100; alarm_set = 1'b1; alarm_on = 1'b1;
            @(negedge clk);
            alarm_set = 1'b0;
            check("alarm_set_ok", i_err, 1'b0);
            hit_at = 0; hit_tm = '0;
            for (int c = 2; c <= 245; c++) begin
                @(negedge clk);
                if (i_alarm && hit_at == 0) begin
                    hit_at = c;
                    hit_tm = i_tm;
                end
            end
            check("alarm_at", hit_at, 240);
            check("alarm_tm", hit_tm, 24'h000100);
            check("alarm_held", i_alarm, 1'b1);
            alarm_ack = 1'b1;
            @(negedge clk);
            alarm_ack = 1'b0;
            check("alarm_ack", i_alarm, 1'b0);
            set_tm = 24'h006000; alarm_set = 1'b1;
            @(negedge clk);
            alarm_set = 1'b0;
            check("alarm_rej", i_err, 1'b1);
            load_i(24'h000100);
            check("alarm_load_nofire", i_alarm, 1'b0);
            sw_i = 1'b1;
            @(negedge clk);
            sw_i = 1'b0;
            set_tm = 24'h000100; alarm_set = 1'b1; alarm_on = 1'b0;
            @(negedge clk);
            alarm_set = 1'b0;
            hits = 0;
            repeat (250) begin
                @(negedge clk);
                if (i_alarm) hits++;
            end
            check("alarm_off", hits, 0);
        end
`else
        set_tm = 24'h996000; alarm_set = 1'b1; alarm_on = 1'b1;
        @(negedge clk);
        alarm_set = 1'b0;
        check("alarm_ignored_err", i_err, 1'b0);
        check("alarm_tied", i_alarm, 1'b0);
        alarm_on = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
